// File: rtl/writeback_sequencer.sv
// Writeback sequencer: merges ALU results, buffered load returns and JAL link writes
// onto the register-file write/link ports. Optional perf counters: WB_PERF_CNT_EN.
module writeback_sequencer #(
  parameter int LOAD_FIFO_DEPTH = 4,
  parameter int MAX_WAIT        = 8,
  parameter int PERF_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        jal_valid,
  input  logic [31:0] jal_link,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        JumpAndLink,
  output logic [31:0] jal_addr,
  output logic [31:0] pending_mask
`ifdef WB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_alu_stall_cnt,
  output logic [PERF_W-1:0] perf_r0_drop_cnt
`endif
);

  localparam int PTR_W  = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(LOAD_FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [4:0]        LINK_REG   = 5'd31;

  if ((LOAD_FIFO_DEPTH < 2) || ((LOAD_FIFO_DEPTH & (LOAD_FIFO_DEPTH - 1)) != 0) ||
      (MAX_WAIT < 1) || (PERF_W < 2)) begin : g_bad_params
    $error("writeback_sequencer: unsupported parameter set");
  end

  logic [4:0]        fifo_addr_r [LOAD_FIFO_DEPTH];
  logic [31:0]       fifo_data_r [LOAD_FIFO_DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic [WAIT_W-1:0] wait_r;

  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        load_prio_s;
  logic        head_link_clash_s;
  logic        push_s;
  logic        pop_s;
  logic        issue_s;
  logic        wr_en_s;
  logic [4:0]  issue_addr_s;
  logic [31:0] issue_data_s;
  logic [PTR_W-1:0] slot_off_s;

  // Per-cycle arbitration: FIFO head wins when full or starved, otherwise the ALU;
  // a candidate targeting r31 is held back while a JAL link write is requested.
  always_comb begin
    fifo_empty_s      = (count_r == {CNT_W{1'b0}});
    fifo_full_s       = (count_r == DEPTH_C);
    load_prio_s       = fifo_full_s || (wait_r >= MAX_WAIT_C);
    head_link_clash_s = jal_valid && (fifo_addr_r[head_r] == LINK_REG);
    alu_ready    = 1'b0;
    pop_s        = 1'b0;
    issue_s      = 1'b0;
    issue_addr_s = 5'd0;
    issue_data_s = 32'd0;
    if (rst) begin
      alu_ready = 1'b0;
    end else if (load_prio_s || !alu_valid) begin
      if (!fifo_empty_s && !head_link_clash_s) begin
        pop_s        = 1'b1;
        issue_s      = 1'b1;
        issue_addr_s = fifo_addr_r[head_r];
        issue_data_s = fifo_data_r[head_r];
      end else begin
        pop_s = 1'b0;
      end
    end else if (!(jal_valid && (alu_addr == LINK_REG))) begin
      alu_ready    = 1'b1;
      issue_s      = 1'b1;
      issue_addr_s = alu_addr;
      issue_data_s = alu_data;
    end else begin
      alu_ready = 1'b0;
    end
    wr_en_s  = issue_s && (issue_addr_s != 5'd0);
    ld_ready = !rst && !fifo_full_s;
    push_s   = ld_valid && ld_ready && (ld_addr != 5'd0);
  end

  // Load FIFO payload storage; validity is tracked by the pointers below.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[tail_r] <= ld_addr;
      fifo_data_r[tail_r] <= ld_data;
    end else begin
      fifo_addr_r[tail_r] <= fifo_addr_r[tail_r];
    end
  end

  // Load FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + PTR_W'(1'b1);
      else        tail_r <= tail_r;
      if (pop_s) head_r <= head_r + PTR_W'(1'b1);
      else       head_r <= head_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter: cycles the FIFO has held data without a pop, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r <= {WAIT_W{1'b0}};
    end else if (pop_s || fifo_empty_s) begin
      wait_r <= {WAIT_W{1'b0}};
    end else if (wait_r < MAX_WAIT_C) begin
      wait_r <= wait_r + WAIT_W'(1'b1);
    end else begin
      wait_r <= wait_r;
    end
  end

  // Registered register-file write and link ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en       <= 1'b0;
      wr_addr     <= 5'd0;
      wr_data     <= 32'd0;
      JumpAndLink <= 1'b0;
      jal_addr    <= 32'd0;
    end else begin
      wr_en       <= wr_en_s;
      wr_addr     <= wr_en_s ? issue_addr_s : 5'd0;
      wr_data     <= wr_en_s ? issue_data_s : 32'd0;
      JumpAndLink <= jal_valid;
      jal_addr    <= jal_valid ? jal_link : 32'd0;
    end
  end

  // Pending-write scoreboard: queued loads plus the write currently on wr_*.
  always_comb begin
    pending_mask = 32'd0;
    slot_off_s   = {PTR_W{1'b0}};
    for (int i = 0; i < LOAD_FIFO_DEPTH; i++) begin
      slot_off_s = PTR_W'(i) - head_r;
      if (CNT_W'(slot_off_s) < count_r) begin
        pending_mask[fifo_addr_r[i]] = 1'b1;
      end else begin
        pending_mask = pending_mask;
      end
    end
    if (wr_en) begin
      pending_mask[wr_addr] = 1'b1;
    end else begin
      pending_mask = pending_mask;
    end
    pending_mask[0] = 1'b0;
  end

`ifdef WB_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
  logic [1:0] r0_drops_s;

  // Number of r0-targeted requests accepted this cycle (ALU and load may coincide).
  always_comb begin
    r0_drops_s = 2'(alu_ready && (alu_addr == 5'd0)) +
                 2'(ld_valid && ld_ready && (ld_addr == 5'd0));
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_alu_stall_cnt <= {PERF_W{1'b0}};
      perf_r0_drop_cnt   <= {PERF_W{1'b0}};
    end else begin
      if (alu_valid && !alu_ready && (perf_alu_stall_cnt != PERF_MAX))
        perf_alu_stall_cnt <= perf_alu_stall_cnt + PERF_W'(1'b1);
      else
        perf_alu_stall_cnt <= perf_alu_stall_cnt;
      if ((PERF_MAX - perf_r0_drop_cnt) < PERF_W'(r0_drops_s))
        perf_r0_drop_cnt <= PERF_MAX;
      else
        perf_r0_drop_cnt <= perf_r0_drop_cnt + PERF_W'(r0_drops_s);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_sequencer.sv
// Self-checking bench for writeback_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_writeback_sequencer;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;
  localparam int PW    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid, ld_valid, jal_valid;
  logic [4:0]  alu_addr, ld_addr;
  logic [31:0] alu_data, ld_data, jal_link;
  logic        alu_ready, ld_ready, wr_en, JumpAndLink;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, jal_addr, pending_mask;
`ifdef WB_PERF_CNT_EN
  logic [PW-1:0] perf_alu_stall_cnt, perf_r0_drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  writeback_sequencer #(.LOAD_FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .jal_valid(jal_valid), .jal_link(jal_link),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .JumpAndLink(JumpAndLink), .jal_addr(jal_addr), .pending_mask(pending_mask)
`ifdef WB_PERF_CNT_EN
    , .perf_alu_stall_cnt(perf_alu_stall_cnt), .perf_r0_drop_cnt(perf_r0_drop_cnt)
`endif
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: FIFO as a queue of {addr,data}, starvation age as an integer.
  logic [36:0] q[$];
  int          wait_m = 0;
  logic        exp_wr_en = 1'b0, exp_jal = 1'b0;
  logic [4:0]  exp_wr_addr = 5'd0;
  logic [31:0] exp_wr_data = 32'd0, exp_jal_addr = 32'd0;
  int          perf_stall_m = 0, perf_r0_m = 0;

  always @(negedge clk) begin : model_cmp
    logic        full, prio, acc_alu, pop, push, issue;
    logic [4:0]  iaddr;
    logic [31:0] idata, pm;
    if (rst) begin
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      q.delete();
      wait_m = 0; exp_wr_en = 1'b0; exp_wr_addr = 5'd0; exp_wr_data = 32'd0;
      exp_jal = 1'b0; exp_jal_addr = 32'd0; perf_stall_m = 0; perf_r0_m = 0;
    end else begin
      pm = exp_wr_en ? (32'd1 << exp_wr_addr) : 32'd0;
      foreach (q[i]) pm = pm | (32'd1 << q[i][36:32]);
      pm[0] = 1'b0;
      chk("m_wr_en", {31'd0, wr_en}, {31'd0, exp_wr_en});
      if (exp_wr_en) begin
        chk("m_wr_addr", {27'd0, wr_addr}, {27'd0, exp_wr_addr});
        chk("m_wr_data", wr_data, exp_wr_data);
      end
      chk("m_jal", {31'd0, JumpAndLink}, {31'd0, exp_jal});
      if (exp_jal) chk("m_jal_addr", jal_addr, exp_jal_addr);
      chk("m_pending", pending_mask, pm);
`ifdef WB_PERF_CNT_EN
      chk("m_perf_stall", 32'(perf_alu_stall_cnt), 32'(perf_stall_m));
      chk("m_perf_r0", 32'(perf_r0_drop_cnt), 32'(perf_r0_m));
`endif
      full = (q.size() == DEPTH);
      prio = full || (wait_m >= MAXW);
      acc_alu = 1'b0; pop = 1'b0; issue = 1'b0; iaddr = 5'd0; idata = 32'd0;
      if (!prio && alu_valid) begin
        if (!(jal_valid && alu_addr == 5'd31)) begin
          acc_alu = 1'b1; issue = 1'b1; iaddr = alu_addr; idata = alu_data;
        end
      end else if (q.size() > 0 && !(jal_valid && q[0][36:32] == 5'd31)) begin
        pop = 1'b1; issue = 1'b1; iaddr = q[0][36:32]; idata = q[0][31:0];
      end
      chk("m_alu_ready", {31'd0, alu_ready}, {31'd0, acc_alu});
      chk("m_ld_ready", {31'd0, ld_ready}, {31'd0, !full});
      push = ld_valid && !full && (ld_addr != 5'd0);
      if (alu_valid && !acc_alu && perf_stall_m < (1 << PW) - 1) perf_stall_m++;
      perf_r0_m += int'(acc_alu && alu_addr == 5'd0) + int'(ld_valid && !full && ld_addr == 5'd0);
      if (perf_r0_m > (1 << PW) - 1) perf_r0_m = (1 << PW) - 1;
      wait_m = (pop || q.size() == 0) ? 0 : ((wait_m < MAXW) ? wait_m + 1 : MAXW);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({ld_addr, ld_data});
      exp_wr_en    = issue && (iaddr != 5'd0);
      exp_wr_addr  = iaddr;
      exp_wr_data  = idata;
      exp_jal      = jal_valid;
      exp_jal_addr = jal_link;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'd0;
    jal_valid = 1'b0; jal_link = 32'd0;
  endtask

  function automatic logic [4:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 5'd31;
    else if (r == 2) return 5'd0;
    else return 5'($urandom_range(1, 30));
  endfunction

  initial begin
    int first_wr, stall_k, alu_pct;
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // r0 requests are accepted but never written or queued
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h5555_5555;
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h6666_6666;
    @(negedge clk);
    chk("r0_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("r0_ld_ready", {31'd0, ld_ready}, 32'd1);
    step(); idle();
    @(negedge clk);
    chk("r0_wr_en", {31'd0, wr_en}, 32'd0);
    chk("r0_pending", pending_mask, 32'd0);
`ifdef WB_PERF_CNT_EN
    chk("r0_perf_cnt", 32'(perf_r0_drop_cnt), 32'd2);
`endif
    step();
    @(negedge clk);
    chk("r0_wr_en_late", {31'd0, wr_en}, 32'd0);

    // single ALU write
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("alu_ready", {31'd0, alu_ready}, 32'd1);
    step(); idle();
    @(negedge clk);
    chk("alu_wr_en", {31'd0, wr_en}, 32'd1);
    chk("alu_wr_addr", {27'd0, wr_addr}, 32'd5);
    chk("alu_wr_data", wr_data, 32'hDEAD_BEEF);
    chk("alu_pending", pending_mask, 32'h0000_0020);
    step();
    @(negedge clk);
    chk("alu_wr_en_off", {31'd0, wr_en}, 32'd0);
    chk("alu_pending_off", pending_mask, 32'd0);

    // JAL and ALU both targeting r31
    alu_valid = 1'b1; alu_addr = 5'd31; alu_data = 32'h0000_AAAA;
    jal_valid = 1'b1; jal_link = 32'h0000_0400;
    @(negedge clk);
    chk("jal_alu_blocked", {31'd0, alu_ready}, 32'd0);
    step(); jal_valid = 1'b0; jal_link = 32'd0;
    @(negedge clk);
    chk("jal_link_en", {31'd0, JumpAndLink}, 32'd1);
    chk("jal_link_addr", jal_addr, 32'h0000_0400);
    chk("jal_no_wr", {31'd0, wr_en}, 32'd0);
    chk("jal_alu_retry", {31'd0, alu_ready}, 32'd1);
    step(); idle();
    @(negedge clk);
    chk("jal_deferred_wr", {31'd0, wr_en}, 32'd1);
    chk("jal_deferred_addr", {27'd0, wr_addr}, 32'd31);
    chk("jal_link_off", {31'd0, JumpAndLink}, 32'd0);

    // starvation guard: load to r7 under continuous ALU traffic
    step();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h1234;
    first_wr = -1; stall_k = -1;
    for (int k = 1; k <= 20; k++) begin
      step(); ld_valid = 1'b0;
      @(negedge clk);
      if (first_wr < 0 && wr_en && wr_addr == 5'd7) first_wr = k;
      if (stall_k < 0 && !alu_ready) stall_k = k;
    end
    chk("starve_stall_cycle", 32'(stall_k), 32'd9);
    chk("starve_wr_cycle", 32'(first_wr), 32'd10);

    // fill the FIFO, then drain back-to-back
    for (int j = 0; j < 4; j++) begin
      step();
      ld_valid = 1'b1; ld_addr = 5'(10 + j); ld_data = 32'(256 + j);
    end
    step();
    alu_valid = 1'b0; ld_valid = 1'b1; ld_addr = 5'd14; ld_data = 32'h999;
    @(negedge clk);
    chk("full_ld_ready", {31'd0, ld_ready}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      step(); idle();
      @(negedge clk);
      chk("drain_wr_en", {31'd0, wr_en}, 32'd1);
      chk("drain_wr_addr", {27'd0, wr_addr}, 32'(10 + j));
    end
    step();
    @(negedge clk);
    chk("full_no_passthru", {31'd0, wr_en}, 32'd0);

    // pending mask for loads to r3 and r9 while ALU is busy on r0
    step();
    alu_valid = 1'b1; alu_addr = 5'd0; ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h33;
    step(); ld_addr = 5'd9; ld_data = 32'h99;
    step(); ld_valid = 1'b0;
    @(negedge clk);
    chk("pend_queued", pending_mask, 32'h0000_0208);
    step(); idle();
    @(negedge clk);
    chk("pend_pop1", pending_mask, 32'h0000_0208);
    step();
    @(negedge clk);
    chk("pend_wr3", pending_mask, 32'h0000_0208);
    chk("pend_wr3_addr", {27'd0, wr_addr}, 32'd3);
    step();
    @(negedge clk);
    chk("pend_wr9", pending_mask, 32'h0000_0200);
    chk("pend_wr9_addr", {27'd0, wr_addr}, 32'd9);
    step();
    @(negedge clk);
    chk("pend_clear", pending_mask, 32'd0);

    // reset with three loads queued
    step();
    alu_valid = 1'b1; alu_addr = 5'd0; ld_valid = 1'b1; ld_addr = 5'd4;
    step(); ld_addr = 5'd5;
    step(); ld_addr = 5'd6;
    step(); ld_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_alu_ready", {31'd0, alu_ready}, 32'd0);
    step(); rst = 1'b0; idle();
    @(negedge clk);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_jal", {31'd0, JumpAndLink}, 32'd0);
    chk("rst_jal_addr", jal_addr, 32'd0);
    chk("rst_pending", pending_mask, 32'd0);
    chk("rst_ld_ready_after", {31'd0, ld_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      @(negedge clk);
      chk("rst_no_replay", {31'd0, wr_en}, 32'd0);
    end

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      step();
      alu_pct   = (c < 1500) ? 6 : 9;
      rst       = ($urandom_range(0, 199) == 0);
      alu_valid = ($urandom_range(0, 9) < alu_pct);
      alu_addr  = rand_addr();
      alu_data  = $urandom();
      ld_valid  = ($urandom_range(0, 9) < 4);
      ld_addr   = rand_addr();
      ld_data   = $urandom();
      jal_valid = ($urandom_range(0, 3) == 0);
      jal_link  = $urandom();
    end
    step(); rst = 1'b0; idle();
    step();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
